// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared encodings for the multi-cycle MIPS control slice
// Purpose: opcode/funct values, ALU function codes, datapath mux encodings,
//          FSM state encoding and the decoded-instruction record.
// Ports:   none (package).
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL   = 6'h00;
    localparam logic [5:0] FN_SRL   = 6'h02;
    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_JALR  = 6'h09;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_SLT   = 6'h2A;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_AND   = 4'd2,
        ALU_OR    = 4'd3,
        ALU_SLT   = 4'd4,
        ALU_SLL   = 4'd5,
        ALU_SRL   = 4'd6,
        ALU_PASSB = 4'd7
    } alu_op_e;

    localparam logic [1:0] NPC_PLUS4  = 2'b00;
    localparam logic [1:0] NPC_BRANCH = 2'b01;
    localparam logic [1:0] NPC_JUMP   = 2'b10;
    localparam logic [1:0] NPC_JR     = 2'b11;

    localparam logic [1:0] WD_ALU   = 2'b00;
    localparam logic [1:0] WD_MEM   = 2'b01;
    localparam logic [1:0] WD_PC4   = 2'b10;

    localparam logic [1:0] GPR_RD   = 2'b00;
    localparam logic [1:0] GPR_RT   = 2'b01;
    localparam logic [1:0] GPR_R31  = 2'b10;

    localparam logic [2:0] SRCB_RD2   = 3'd0;
    localparam logic [2:0] SRCB_IMM   = 3'd1;
    localparam logic [2:0] SRCB_SA    = 3'd2;
    localparam logic [2:0] SRCB_UPPER = 3'd3;

    typedef enum logic [2:0] {
        S_IF  = 3'd0,
        S_ID  = 3'd1,
        S_EXE = 3'd2,
        S_MEM = 3'd3,
        S_WB  = 3'd4
    } state_e;

    typedef enum logic [3:0] {
        CL_R, CL_I, CL_LW, CL_SW, CL_BEQ, CL_BNE,
        CL_J, CL_JAL, CL_JR, CL_JALR, CL_ILL
    } ins_class_e;

    typedef struct packed {
        ins_class_e cls;
        alu_op_e    alu_op;
        logic       ext_op;
        logic       alu_src_a;
        logic [2:0] alu_src_b;
        logic       legal;
    } dec_t;

endpackage

// File: rtl/mc_decode.sv
// rtl/mc_decode.sv - combinational Op/Funct decoder for the multi-cycle controller
// Purpose: classify the instruction and produce its ALU-side datapath fields.
// Ports:   op (in 6), funct (in 6), dec (out dec_t: class, ALU fields, legal).
import mips_pkg::*;

module mc_decode (
    input  logic [5:0] op,
    input  logic [5:0] funct,
    output dec_t       dec
);

    always_comb begin
        dec = '{cls: CL_ILL, alu_op: ALU_ADD, ext_op: 1'b0,
                alu_src_a: 1'b0, alu_src_b: SRCB_RD2, legal: 1'b1};
        case (op)
            OP_RTYPE: begin
                dec.cls = CL_R;
                case (funct)
                    FN_ADD:  dec.alu_op = ALU_ADD;
                    FN_SUB:  dec.alu_op = ALU_SUB;
                    FN_AND:  dec.alu_op = ALU_AND;
                    FN_OR:   dec.alu_op = ALU_OR;
                    FN_SLT:  dec.alu_op = ALU_SLT;
                    FN_SLL: begin
                        dec.alu_op    = ALU_SLL;
                        dec.alu_src_a = 1'b1;
                        dec.alu_src_b = SRCB_SA;
                    end
                    FN_SRL: begin
                        dec.alu_op    = ALU_SRL;
                        dec.alu_src_a = 1'b1;
                        dec.alu_src_b = SRCB_SA;
                    end
                    FN_JR:   dec.cls = CL_JR;
                    FN_JALR: dec.cls = CL_JALR;
                    default: begin
                        dec.cls   = CL_ILL;
                        dec.legal = 1'b0;
                    end
                endcase
            end
            OP_ADDI: begin
                dec.cls = CL_I;  dec.ext_op = 1'b1;  dec.alu_src_b = SRCB_IMM;
            end
            OP_ORI: begin
                dec.cls = CL_I;  dec.alu_op = ALU_OR;  dec.alu_src_b = SRCB_IMM;
            end
            OP_LUI: begin
                // Upper-immediate goes straight through the ALU on port B.
                dec.cls = CL_I;  dec.alu_op = ALU_PASSB;  dec.ext_op = 1'b1;
                dec.alu_src_b = SRCB_UPPER;
            end
            OP_LW: begin
                dec.cls = CL_LW;  dec.ext_op = 1'b1;  dec.alu_src_b = SRCB_IMM;
            end
            OP_SW: begin
                dec.cls = CL_SW;  dec.ext_op = 1'b1;  dec.alu_src_b = SRCB_IMM;
            end
            OP_BEQ: begin
                dec.cls = CL_BEQ;  dec.alu_op = ALU_SUB;  dec.ext_op = 1'b1;
            end
            OP_BNE: begin
                dec.cls = CL_BNE;  dec.alu_op = ALU_SUB;  dec.ext_op = 1'b1;
            end
            OP_J:    dec.cls = CL_J;
            OP_JAL:  dec.cls = CL_JAL;
            default: dec.legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/mc_ctrl.sv
// rtl/mc_ctrl.sv - multi-cycle IF/ID/EXE/MEM/WB sequencer for the MIPS datapath
// Purpose: steps each instruction through the shared req/rdy memory port and
//          drives the datapath strobes and mux selects.
// Ports:   clk, rst (async active-low), Op/Funct (IR fields), Zero (ALU flag),
//          mem_rdy (access completes) in; mem_req, mem_ifetch, IRWrite, PCWrite,
//          RegWrite, MemWrite, EXTOp, ALUOp[4], NPCOp[2], WDSel[2], GPRSel[2],
//          ALUSrcA, ALUSrcB[3], retire, illegal (sticky), mem_err (sticky) out.
import mips_pkg::*;

module mc_ctrl #(
    parameter int MEM_TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] Op,
    input  logic [5:0] Funct,
    input  logic       Zero,
    input  logic       mem_rdy,
    output logic       mem_req,
    output logic       mem_ifetch,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic       RegWrite,
    output logic       MemWrite,
    output logic       EXTOp,
    output logic [3:0] ALUOp,
    output logic [1:0] NPCOp,
    output logic [1:0] WDSel,
    output logic [1:0] GPRSel,
    output logic       ALUSrcA,
    output logic [2:0] ALUSrcB,
    output logic       retire,
    output logic       illegal,
    output logic       mem_err
);

    localparam logic [15:0] TO_LAST = 16'(MEM_TIMEOUT - 1);

    state_e      state;
    logic [5:0]  op_q, funct_q;
    logic [15:0] wait_cnt;
    logic        active_q;   // keeps mem_req low while held in reset
    logic        drop_q;     // one-cycle request gap after a timeout
    logic        illegal_q, mem_err_q;
    logic        xfer, waiting, taken;
    dec_t        dec;

    mc_decode u_decode (.op(op_q), .funct(funct_q), .dec(dec));

    assign mem_req = active_q && !drop_q && (state == S_IF || state == S_MEM);
    assign xfer    = mem_req && mem_rdy;
    assign waiting = mem_req && !mem_rdy;
    assign taken   = (dec.cls == CL_BEQ && Zero) || (dec.cls == CL_BNE && !Zero);
    assign illegal = illegal_q;
    assign mem_err = mem_err_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IF;
            op_q      <= '0;
            funct_q   <= '0;
            wait_cnt  <= '0;
            active_q  <= 1'b0;
            drop_q    <= 1'b0;
            illegal_q <= 1'b0;
            mem_err_q <= 1'b0;
        end else begin
            active_q <= 1'b1;
            drop_q   <= 1'b0;
            // IR is stable from ID on; capture it so decode is independent of it.
            if (state == S_ID) begin
                op_q    <= Op;
                funct_q <= Funct;
            end
            if (state == S_EXE && !dec.legal)
                illegal_q <= 1'b1;
            // Any cycle without a pending access (completion, gap, other
            // states) clears the counter, which also covers state changes.
            if (waiting) begin
                if (MEM_TIMEOUT != 0 && wait_cnt == TO_LAST) begin
                    mem_err_q <= 1'b1;
                    drop_q    <= 1'b1;
                    wait_cnt  <= '0;
                end else begin
                    wait_cnt <= wait_cnt + 16'd1;
                end
            end else begin
                wait_cnt <= '0;
            end
            case (state)
                S_IF:  if (xfer) state <= S_ID;
                S_ID:  state <= S_EXE;
                S_EXE: case (dec.cls)
                           CL_LW, CL_SW: state <= S_MEM;
                           CL_R, CL_I:   state <= S_WB;
                           default:      state <= S_IF;
                       endcase
                S_MEM: if (xfer) state <= (dec.cls == CL_SW) ? S_IF : S_WB;
                S_WB:  state <= S_IF;
                default: state <= S_IF;
            endcase
        end
    end

    always_comb begin
        mem_ifetch = mem_req && (state == S_IF);
        IRWrite  = 1'b0;
        PCWrite  = 1'b0;
        RegWrite = 1'b0;
        MemWrite = 1'b0;
        retire   = 1'b0;
        EXTOp    = 1'b0;
        ALUOp    = 4'd0;
        ALUSrcA  = 1'b0;
        ALUSrcB  = SRCB_RD2;
        NPCOp    = NPC_PLUS4;
        WDSel    = WD_ALU;
        GPRSel   = GPR_RD;
        if (state == S_EXE || state == S_MEM || state == S_WB) begin
            EXTOp   = dec.ext_op;
            ALUOp   = dec.alu_op;
            ALUSrcA = dec.alu_src_a;
            ALUSrcB = dec.alu_src_b;
        end
        case (state)
            S_IF: IRWrite = xfer;
            S_EXE: case (dec.cls)
                CL_BEQ, CL_BNE: begin
                    PCWrite = 1'b1;  retire = 1'b1;
                    NPCOp   = taken ? NPC_BRANCH : NPC_PLUS4;
                end
                CL_J: begin
                    PCWrite = 1'b1;  retire = 1'b1;  NPCOp = NPC_JUMP;
                end
                CL_JAL: begin
                    PCWrite = 1'b1;  retire = 1'b1;  NPCOp = NPC_JUMP;
                    RegWrite = 1'b1; GPRSel = GPR_R31; WDSel = WD_PC4;
                end
                CL_JR: begin
                    PCWrite = 1'b1;  retire = 1'b1;  NPCOp = NPC_JR;
                end
                CL_JALR: begin
                    PCWrite = 1'b1;  retire = 1'b1;  NPCOp = NPC_JR;
                    RegWrite = 1'b1; GPRSel = GPR_RD; WDSel = WD_PC4;
                end
                CL_ILL: begin
                    PCWrite = 1'b1;  retire = 1'b1;
                end
                default: ;
            endcase
            S_MEM: if (dec.cls == CL_SW) begin
                MemWrite = xfer;  PCWrite = xfer;  retire = xfer;
            end
            S_WB: begin
                RegWrite = 1'b1;  PCWrite = 1'b1;  retire = 1'b1;
                if (dec.cls == CL_LW) begin
                    GPRSel = GPR_RT;  WDSel = WD_MEM;
                end else if (dec.cls == CL_I) begin
                    GPRSel = GPR_RT;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mc_ctrl.sv
// tb/tb_mc_ctrl.sv - directed self-checking bench for mc_ctrl
module tb_mc_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] Op, Funct;
    logic       Zero, mem_rdy;
    logic       mem_req, mem_ifetch, IRWrite, PCWrite, RegWrite, MemWrite, EXTOp;
    logic [3:0] ALUOp;
    logic [1:0] NPCOp, WDSel, GPRSel;
    logic       ALUSrcA;
    logic [2:0] ALUSrcB;
    logic       retire, illegal, mem_err;

    int n_tests = 0;
    int n_fail  = 0;

    mc_ctrl #(.MEM_TIMEOUT(4)) dut (
        .clk(clk), .rst(rst), .Op(Op), .Funct(Funct), .Zero(Zero), .mem_rdy(mem_rdy),
        .mem_req(mem_req), .mem_ifetch(mem_ifetch), .IRWrite(IRWrite), .PCWrite(PCWrite),
        .RegWrite(RegWrite), .MemWrite(MemWrite), .EXTOp(EXTOp), .ALUOp(ALUOp),
        .NPCOp(NPCOp), .WDSel(WDSel), .GPRSel(GPRSel), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .retire(retire), .illegal(illegal), .mem_err(mem_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle's inputs just after the falling edge, then let
    // combinational outputs settle before the caller samples them.
    task automatic step(input logic [5:0] op, input logic [5:0] fn,
                        input logic z, input logic rdy);
        @(negedge clk);
        Op = op; Funct = fn; Zero = z; mem_rdy = rdy;
        #1;
    endtask

    function automatic logic [31:0] all_outs();
        return {8'd0, mem_req, mem_ifetch, IRWrite, PCWrite, RegWrite, MemWrite, EXTOp,
                ALUOp, NPCOp, WDSel, GPRSel, ALUSrcA, ALUSrcB, retire, illegal, mem_err};
    endfunction

    initial begin
        rst = 1'b0; Op = '0; Funct = '0; Zero = 1'b0; mem_rdy = 1'b0;
        #1;
        check("reset_all_zero", all_outs(), 32'd0);
        @(negedge clk); @(negedge clk);
        rst = 1'b1;
        step(6'h00, 6'h20, 0, 0);
        check("post_reset_req", {mem_req, mem_ifetch}, 2'b11);

        // add, memory always ready
        step(6'h00, 6'h20, 0, 1);
        check("add_c0_irwrite", {IRWrite, mem_req, mem_ifetch, retire}, 4'b1110);
        step(6'h00, 6'h20, 0, 1);
        check("add_c1_id", {IRWrite, mem_req, PCWrite, retire}, 4'b0000);
        step(6'h00, 6'h20, 0, 1);
        check("add_c2_exe", {PCWrite, RegWrite, retire, ALUOp, ALUSrcB}, {3'b000, 4'd0, 3'd0});
        step(6'h00, 6'h20, 0, 1);
        check("add_c3_wb", {RegWrite, PCWrite, retire, NPCOp, GPRSel, WDSel}, {3'b111, 6'd0});

        // lw with three wait cycles in MEM
        step(6'h23, 6'h00, 0, 1);
        check("lw_if", {IRWrite, retire, mem_ifetch}, 3'b101);
        step(6'h23, 6'h00, 0, 1);
        step(6'h23, 6'h00, 0, 1);
        check("lw_exe", {PCWrite, ALUOp, ALUSrcB, EXTOp}, {1'b0, 4'd0, 3'd1, 1'b1});
        for (int i = 0; i < 3; i++) begin
            step(6'h23, 6'h00, 0, 0);
            check("lw_mem_wait", {mem_req, mem_ifetch, MemWrite, retire}, 4'b1000);
        end
        step(6'h23, 6'h00, 0, 1);
        check("lw_mem_done", {mem_req, mem_ifetch, PCWrite, retire}, 4'b1000);
        step(6'h23, 6'h00, 0, 1);
        check("lw_wb", {RegWrite, PCWrite, retire, GPRSel, WDSel}, {3'b111, 2'b01, 2'b01});
        step(6'h23, 6'h00, 0, 1);
        check("lw_back_to_if", {retire, mem_ifetch, IRWrite}, 3'b011);

        // beq taken (already in IF above), Zero=1
        step(6'h04, 6'h00, 1, 1);
        step(6'h04, 6'h00, 1, 1);
        check("beq_exe", {PCWrite, NPCOp, retire, ALUOp}, {1'b1, 2'b01, 1'b1, 4'd1});
        step(6'h05, 6'h00, 1, 1);
        check("beq_3cyc_if", {mem_ifetch, IRWrite, retire}, 3'b110);
        step(6'h05, 6'h00, 1, 1);
        step(6'h05, 6'h00, 1, 1);
        check("bne_exe", {PCWrite, NPCOp, retire}, {1'b1, 2'b00, 1'b1});

        // jal
        step(6'h03, 6'h00, 0, 1);
        step(6'h03, 6'h00, 0, 1);
        step(6'h03, 6'h00, 0, 1);
        check("jal_exe", {RegWrite, GPRSel, WDSel, NPCOp, PCWrite, retire},
              {1'b1, 2'b10, 2'b10, 2'b10, 1'b1, 1'b1});

        // jr
        step(6'h00, 6'h08, 0, 1);
        step(6'h00, 6'h08, 0, 1);
        step(6'h00, 6'h08, 0, 1);
        check("jr_exe", {NPCOp, PCWrite, RegWrite, retire}, {2'b11, 1'b1, 1'b0, 1'b1});

        // sw
        step(6'h2B, 6'h00, 0, 1);
        step(6'h2B, 6'h00, 0, 1);
        step(6'h2B, 6'h00, 0, 1);
        check("sw_exe", {PCWrite, retire, EXTOp}, 3'b001);
        step(6'h2B, 6'h00, 0, 1);
        check("sw_mem", {mem_ifetch, MemWrite, PCWrite, NPCOp, retire}, {3'b011, 2'b00, 1'b1});

        // sll: shift operand on port A, shamt on port B
        step(6'h00, 6'h00, 0, 1);
        step(6'h00, 6'h00, 0, 1);
        step(6'h00, 6'h00, 0, 1);
        check("sll_exe", {ALUSrcA, ALUSrcB, ALUOp}, {1'b1, 3'd2, 4'd5});
        step(6'h00, 6'h00, 0, 1);

        // ori: zero extension, writes rt from the ALU
        step(6'h0D, 6'h00, 0, 1);
        step(6'h0D, 6'h00, 0, 1);
        step(6'h0D, 6'h00, 0, 1);
        check("ori_exe", {EXTOp, ALUOp, ALUSrcB}, {1'b0, 4'd3, 3'd1});
        step(6'h0D, 6'h00, 0, 1);
        check("ori_wb", {RegWrite, GPRSel, WDSel}, {1'b1, 2'b01, 2'b00});

        // lui
        step(6'h0F, 6'h00, 0, 1);
        step(6'h0F, 6'h00, 0, 1);
        step(6'h0F, 6'h00, 0, 1);
        check("lui_exe", {EXTOp, ALUSrcB}, {1'b1, 3'd3});
        step(6'h0F, 6'h00, 0, 1);

        // illegal opcode behaves as a NOP and sets the sticky flag
        step(6'h3F, 6'h00, 0, 1);
        check("ill_before", {illegal}, 1'b0);
        step(6'h3F, 6'h00, 0, 1);
        step(6'h3F, 6'h00, 0, 1);
        check("ill_exe", {PCWrite, NPCOp, retire, RegWrite}, {1'b1, 2'b00, 1'b1, 1'b0});

        // timeout in IF: four waiting cycles, then a one-cycle gap with mem_err
        for (int i = 0; i < 4; i++) begin
            step(6'h23, 6'h00, 0, 0);
            check("to_wait", {illegal, mem_req, mem_ifetch, mem_err}, 4'b1110);
        end
        step(6'h23, 6'h00, 0, 0);
        check("to_gap", {mem_err, mem_req, IRWrite}, 3'b100);
        step(6'h23, 6'h00, 0, 1);
        check("to_retry", {mem_err, mem_req, mem_ifetch, IRWrite}, 4'b1111);

        // lw into MEM, then asynchronous reset mid-access
        step(6'h23, 6'h00, 0, 0);
        step(6'h23, 6'h00, 0, 0);
        step(6'h23, 6'h00, 0, 0);
        check("rst_pre_mem", {mem_req, mem_ifetch}, 2'b10);
        #2 rst = 1'b0;
        #1;
        check("rst_async_zero", all_outs(), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        step(6'h00, 6'h20, 0, 0);
        check("rst_restart_if", {mem_req, mem_ifetch, IRWrite, illegal, mem_err}, 5'b11000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
